// File: rtl/multimode_modulator.sv
// Sample-FIFO driven one-bit modulator: AM (PWM), BPSK or OOK on a square carrier,
// with a symbol clock, gapless back-to-back words and a saturating underrun count.
module multimode_modulator #(
  parameter int SAMPLE_WIDTH           = 8,
  parameter int CLKS_PER_STEP          = 1,
  parameter int PERIODS_PER_SAMPLE     = 1,
  parameter int CLKS_PER_HALF_CARRIER  = 4,
  parameter int CARRIER_CYCLES_PER_BIT = 2,
  parameter int UNDERRUN_WIDTH         = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [SAMPLE_WIDTH-1:0]   sample,
  input  logic                      empty,
  output logic                      read,
  output logic                      pwm,
  output logic                      symb_clk,
  output logic                      busy,
  output logic [UNDERRUN_WIDTH-1:0] underrun_cnt
);
  localparam int W       = SAMPLE_WIDTH;
  localparam int BIT_LEN = 2 * CLKS_PER_HALF_CARRIER * CARRIER_CYCLES_PER_BIT;
  localparam int DW      = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
  localparam int PW      = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
  localparam int BW      = $clog2(BIT_LEN);
  localparam int IW      = (W > 1) ? $clog2(W) : 1;
  localparam int CW      = (CLKS_PER_HALF_CARRIER > 1) ? $clog2(CLKS_PER_HALF_CARRIER) : 1;
  localparam logic [W-1:0] S_LAST = W'((2 ** W) - 2);
  localparam logic [1:0] M_AM = 2'd0, M_BPSK = 2'd1, M_OFF = 2'd3;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  logic [W-1:0]    data;
  logic [1:0]      cur_mode;
  logic [DW-1:0]   step_div, step_div_n;
  logic [W-1:0]    s, s_n;
  logic [PW-1:0]   period, period_n;
  logic [BW-1:0]   bit_clk, bit_clk_n;
  logic [IW-1:0]   bit_idx, bit_idx_n;
  logic [W-1:0]    data_n;
  logic            carrier, carrier_n, car_tick, car_start;
  logic [CW-1:0]   car_div, car_div_n;
  logic            latch_ok, am_last, bit_end, word_last, start_pwm, run_pwm;

  // Counters describe the position currently on pwm; the next position's level
  // is computed here so pwm stays a plain register.
  always_comb begin
    latch_ok  = enable && !empty && (mode != M_OFF);
    am_last   = (step_div == DW'(CLKS_PER_STEP - 1)) && (s == S_LAST) &&
                (period == PW'(PERIODS_PER_SAMPLE - 1));
    bit_end   = (bit_clk == BW'(BIT_LEN - 1));
    word_last = (cur_mode == M_AM) ? am_last : (bit_end && (bit_idx == IW'(W - 1)));
    read      = rst && latch_ok && ((state == IDLE) || word_last);
    car_tick  = (car_div == CW'(CLKS_PER_HALF_CARRIER - 1));
    car_div_n = car_tick ? '0 : car_div + 1'b1;
    carrier_n = carrier ^ car_tick;
    car_start = (state == IDLE) ? 1'b0 : carrier_n;
    if (mode == M_AM)        start_pwm = |sample;
    else if (mode == M_BPSK) start_pwm = car_start ^ sample[W-1];
    else                     start_pwm = car_start & sample[W-1];
    step_div_n = step_div;
    s_n        = s;
    period_n   = period;
    bit_clk_n  = bit_clk;
    bit_idx_n  = bit_idx;
    data_n     = data;
    if (cur_mode == M_AM) begin
      if (step_div == DW'(CLKS_PER_STEP - 1)) begin
        step_div_n = '0;
        if (s == S_LAST) begin
          s_n      = '0;
          period_n = period + 1'b1;
        end else begin
          s_n = s + 1'b1;
        end
      end else begin
        step_div_n = step_div + 1'b1;
      end
    end else if (bit_end) begin
      bit_clk_n = '0;
      bit_idx_n = bit_idx + 1'b1;
      data_n    = data << 1;
    end else begin
      bit_clk_n = bit_clk + 1'b1;
    end
    if (cur_mode == M_AM)        run_pwm = (s_n < data);
    else if (cur_mode == M_BPSK) run_pwm = carrier_n ^ data_n[W-1];
    else                         run_pwm = carrier_n & data_n[W-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      data         <= '0;
      cur_mode     <= '0;
      step_div     <= '0;
      s            <= '0;
      period       <= '0;
      bit_clk      <= '0;
      bit_idx      <= '0;
      carrier      <= 1'b0;
      car_div      <= '0;
      pwm          <= 1'b0;
      symb_clk     <= 1'b0;
      busy         <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (state == RUN) begin
        carrier <= carrier_n;
        car_div <= car_div_n;
      end
      if ((state == IDLE) || word_last) begin
        if (latch_ok) begin
          if (state == IDLE) begin
            carrier <= 1'b0;
            car_div <= '0;
          end
          state    <= RUN;
          busy     <= 1'b1;
          data     <= sample;
          cur_mode <= mode;
          step_div <= '0;
          s        <= '0;
          period   <= '0;
          bit_clk  <= '0;
          bit_idx  <= '0;
          pwm      <= start_pwm;
          symb_clk <= ~symb_clk;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
          pwm   <= 1'b0;
          // Only a word ending with the FIFO dry while still enabled is an underrun.
          if ((state == RUN) && enable && (mode != M_OFF) && (underrun_cnt != '1))
            underrun_cnt <= underrun_cnt + 1'b1;
        end
      end else begin
        step_div <= step_div_n;
        s        <= s_n;
        period   <= period_n;
        bit_clk  <= bit_clk_n;
        bit_idx  <= bit_idx_n;
        data     <= data_n;
        pwm      <= run_pwm;
        if ((cur_mode != M_AM) && bit_end) symb_clk <= ~symb_clk;
      end
    end
  end
endmodule

// File: tb/tb_multimode_modulator.sv
// Directed bench for multimode_modulator: a word-level waveform model plus literal pins.
module tb_multimode_modulator;
  localparam int W   = 8;
  localparam int CPS = 1;
  localparam int PPS = 1;
  localparam int CHC = 4;
  localparam int CCB = 2;
  localparam int BL  = 2 * CHC * CCB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       empty = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] sample = 8'h00;
  logic        read, pwm, symb_clk, busy;
  logic [15:0] ucnt;
  logic        read2, pwm2, symb2, busy2;
  logic [1:0]  ucnt2;

  multimode_modulator dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sample(sample), .empty(empty),
    .read(read), .pwm(pwm), .symb_clk(symb_clk), .busy(busy), .underrun_cnt(ucnt)
  );

  multimode_modulator #(.UNDERRUN_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sample(sample), .empty(empty),
    .read(read2), .pwm(pwm2), .symb_clk(symb2), .busy(busy2), .underrun_cnt(ucnt2)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo_q[$];
  logic [1:0] exp_q[$];
  bit         pop_pend = 1'b0;

  bit m_busy = 1'b0, m_pwm = 1'b0, m_symb = 1'b0;
  int m_under = 0;
  int run_t = 0;

  int   n_read, n_hi, n_busy, n_tog, mon_cyc;
  int   rd_pos[0:7];
  logic hist[0:1023];
  logic last_symb = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected waveform of a whole word, computed from the modulation rules.
  task automatic gen_word(input logic [1:0] md, input logic [7:0] smp, input int t0);
    if (md == 2'd0) begin
      for (int k = 0; k < PPS * 255 * CPS; k++) begin
        int st;
        st = (k / CPS) % 255;
        exp_q.push_back({k == 0, st < int'(smp)});
      end
    end else begin
      for (int k = 0; k < W * BL; k++) begin
        bit b, c;
        b = smp[W - 1 - k / BL];
        c = (((t0 + k) / CHC) % 2) == 1;
        exp_q.push_back({(k % BL) == 0, (md == 2'd1) ? (c ^ b) : (c & b)});
      end
    end
  endtask

  // FIFO: pops on a granted read, head word presented first-word-fall-through.
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      if (fifo_q.size() > 0) fifo_q.delete(0);
      pop_pend = 1'b0;
    end
    empty  = (fifo_q.size() == 0);
    sample = empty ? 8'h00 : fifo_q[0];
  end

  // Compare process and model step, once per cycle on the falling edge.
  always @(negedge clk) begin : cmp
    bit latch_ok, exp_read, was_busy;
    logic [1:0] e;
    int t0, e16, e2;
    e16 = (m_under > 65535) ? 65535 : m_under;
    e2  = (m_under > 3) ? 3 : m_under;
    if (!rst) begin
      check("rst_pwm", pwm, 0);
      check("rst_busy", busy, 0);
      check("rst_symb", symb_clk, 0);
      check("rst_read", read, 0);
      check("rst_ucnt", ucnt, 0);
      check("rst_ucnt2", ucnt2, 0);
      m_busy = 0; m_pwm = 0; m_symb = 0; m_under = 0;
      exp_q.delete();
      pop_pend = 0;
      last_symb = 0;
    end else begin
      latch_ok = enable && !empty && (mode != 2'd3);
      exp_read = latch_ok && (!m_busy || exp_q.size() == 0);
      check("read", read, exp_read);
      check("pwm", pwm, m_pwm);
      check("busy", busy, m_busy);
      check("symb_clk", symb_clk, m_symb);
      check("underrun", ucnt, e16);
      check("read2", read2, exp_read);
      check("pwm2", pwm2, m_pwm);
      check("busy2", busy2, m_busy);
      check("symb2", symb2, m_symb);
      check("underrun2", ucnt2, e2);
      mon_cyc++;
      if (read) begin
        if (n_read < 8) rd_pos[n_read] = mon_cyc;
        n_read++;
        pop_pend = 1;
      end
      if (busy) begin
        if (n_busy < 1024) hist[n_busy] = pwm;
        n_hi += int'(pwm);
        n_busy++;
      end
      if (symb_clk != last_symb) n_tog++;
      last_symb = symb_clk;
      was_busy = m_busy;
      if (exp_read) begin
        t0 = was_busy ? run_t + 1 : 0;
        gen_word(mode, sample, t0);
      end else if (was_busy && exp_q.size() == 0 && enable && mode != 2'd3) begin
        m_under++;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_pwm = e[0];
        if (e[1]) m_symb = ~m_symb;
        run_t = was_busy ? run_t + 1 : 0;
        m_busy = 1;
      end else begin
        m_busy = 0;
        m_pwm = 0;
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_read = 0; n_hi = 0; n_busy = 0; n_tog = 0; mon_cyc = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      cyc(1);
      k++;
    end
    if (busy !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL %s: busy still high after %0d cycles", name, budget);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    check("reset_busy", busy, 0);
    check("reset_pwm", pwm, 0);
    rst = 1'b1;
    cyc(2);

    // AM, single word 0x40
    clear_mon();
    mode = 2'd0; enable = 1'b1; fifo_q.push_back(8'h40);
    cyc(3); wait_idle("t1_done", 400); cyc(2);
    check("t1_reads", n_read, 1);
    check("t1_len", n_busy, 255);
    check("t1_high", n_hi, 64);
    check("t1_hist63", hist[63], 1);
    check("t1_hist64", hist[64], 0);
    check("t1_ucnt", ucnt, 1);

    // AM, three queued words
    clear_mon();
    fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF); fifo_q.push_back(8'h80);
    cyc(3); wait_idle("t2_done", 900); cyc(2);
    check("t2_reads", n_read, 3);
    check("t2_gap0", rd_pos[1] - rd_pos[0], 255);
    check("t2_gap1", rd_pos[2] - rd_pos[1], 255);
    check("t2_len", n_busy, 765);
    check("t2_high", n_hi, 383);
    check("t2_symb", n_tog, 3);
    check("t2_hist254", hist[254], 0);
    check("t2_hist255", hist[255], 1);
    check("t2_hist637", hist[637], 1);
    check("t2_hist638", hist[638], 0);
    check("t2_ucnt", ucnt, 2);

    // BPSK, 0xA5 then 0x5A back-to-back
    clear_mon();
    mode = 2'd1; fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A);
    cyc(3); wait_idle("t3_done", 400); cyc(2);
    check("t3_len", n_busy, 256);
    check("t3_reads", n_read, 2);
    check("t3_symb", n_tog, 16);
    check("t3_high", n_hi, 128);
    check("t3_hist0", hist[0], 1);
    check("t3_hist4", hist[4], 0);
    check("t3_hist16", hist[16], 0);
    check("t3_hist20", hist[20], 1);
    check("t3_hist127", hist[127], 0);
    check("t3_hist128", hist[128], 0);
    check("t3_hist132", hist[132], 1);
    check("t3_ucnt", ucnt, 3);

    // OOK, 0xF0
    clear_mon();
    mode = 2'd2; fifo_q.push_back(8'hF0);
    cyc(3); wait_idle("t4_done", 300); cyc(2);
    check("t4_len", n_busy, 128);
    check("t4_high", n_hi, 32);
    check("t4_hist0", hist[0], 0);
    check("t4_hist4", hist[4], 1);
    check("t4_hist68", hist[68], 0);
    check("t4_ucnt", ucnt, 4);
    check("t4_ucnt2", ucnt2, 3);

    // AM word, then mode -> BPSK and enable dropped mid-word
    clear_mon();
    mode = 2'd0; fifo_q.push_back(8'h10);
    cyc(5);
    mode = 2'd1; enable = 1'b0; fifo_q.push_back(8'h33);
    wait_idle("t5_am_done", 400); cyc(5);
    check("t5_am_len", n_busy, 255);
    check("t5_am_high", n_hi, 16);
    check("t5_reads", n_read, 1);
    check("t5_no_underrun", ucnt, 4);
    check("t5_idle", busy, 0);
    clear_mon();
    enable = 1'b1;
    cyc(3); wait_idle("t5_psk_done", 300); cyc(2);
    check("t5_psk_len", n_busy, 128);
    check("t5_psk_high", n_hi, 64);
    check("t5_psk_hist0", hist[0], 0);
    check("t5_psk_hist4", hist[4], 1);
    check("t5_ucnt", ucnt, 5);
    check("t5_ucnt2", ucnt2, 3);

    // Reset mid-word
    mode = 2'd0; fifo_q.push_back(8'hC3);
    cyc(20);
    check("t6_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_async_pwm", pwm, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_symb", symb_clk, 0);
    check("t6_async_read", read, 0);
    check("t6_async_ucnt", ucnt, 0);
    check("t6_async_ucnt2", ucnt2, 0);
    cyc(2);
    rst = 1'b1;
    cyc(3);
    check("t6_after_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multimode_modulator.md
# multimode_modulator

Parametrised successor to the transmitter's single-purpose modulator. It pops bytes from the first-word-fall-through sample FIFO and drives a one-bit `pwm` line in one of three runtime-selectable modes: PWM amplitude modulation, BPSK on a square carrier, or OOK. It also emits a symbol clock, counts FIFO underruns, and streams back-to-back samples without gaps. It sits between the data FIFO and the differential PWM output pins.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 8: width W of a FIFO word; AM resolution and PSK/OOK bits per word.
- `CLKS_PER_STEP`, 1: clocks per AM PWM step (≥1).
- `PERIODS_PER_SAMPLE`, 1: AM PWM periods per sample (≥1).
- `CLKS_PER_HALF_CARRIER`, 4: PSK/OOK carrier half-period in clocks (≥1).
- `CARRIER_CYCLES_PER_BIT`, 2: full carrier cycles per PSK/OOK bit (≥1).
- `UNDERRUN_WIDTH`, 16: width of the underrun counter.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset. Asynchronous, active-low (block in reset while 0).
- `enable`  in  1: permits new samples to be latched.
- `mode`  in  2: 0 = AM, 1 = BPSK, 2 = OOK, 3 = off. Sampled only at latch.
- `sample`  in  W: FIFO head word, valid while `empty`=0.
- `empty`  in  1: FIFO empty.
- `read`  out  1: one-cycle pop strobe.
- `pwm`  out  1: modulated output, registered.
- `symb_clk`  out  1: toggles at every symbol start.
- `busy`  out  1: high in RUN.
- `underrun_cnt`  out  UNDERRUN_WIDTH: saturating underrun count.

## Operation
- States are IDLE and RUN. Reset values: state IDLE, `pwm`=0, `read`=0, `symb_clk`=0, `busy`=0, `underrun_cnt`=0, all counters 0, carrier 0.
- Latch event:
  - Condition: `enable`=1 and `empty`=0 and `mode`≠3.
  - Action: `read`=1 for that cycle; `sample` and `mode` are captured into registers in the same cycle.
- IDLE:
  - On a latch event, go to RUN and clear the carrier phase.
  - Otherwise stay in IDLE with `pwm`=0.
- RUN, AM mode:
  - The step counter s runs 0..2^W−2 (period of 2^W−1 steps).
  - s advances every `CLKS_PER_STEP` clocks.
  - `pwm` = (s < latched sample). Sample 0 gives constant low; sample 2^W−1 gives constant high.
  - Symbol length = `PERIODS_PER_SAMPLE`·(2^W−1)·`CLKS_PER_STEP` clocks.
- RUN, carrier:
  - The carrier toggles every `CLKS_PER_HALF_CARRIER` clocks and starts low after IDLE.
  - The carrier runs continuously across back-to-back samples; its phase is never reset in RUN.
- RUN, PSK/OOK bits:
  - The word is sent as W bits, MSB first.
  - Bit length = 2·`CLKS_PER_HALF_CARRIER`·`CARRIER_CYCLES_PER_BIT` clocks.
  - BPSK: `pwm` = carrier XOR bit.
  - OOK: `pwm` = carrier AND bit.
- Symbol definition: one sample in AM; one bit in PSK/OOK. `symb_clk` toggles on the first `pwm` cycle of every symbol.
- Last clock of the last symbol of a word:
  - Latch event true: latch the next word in this cycle. No gap and no idle cycle; the first symbol of the new word starts on the next clock.
  - `enable`=1, `empty`=1, `mode`≠3: go to IDLE and increment `underrun_cnt`, saturating at all-ones.
  - `enable`=0 or `mode`=3: go to IDLE with no count.
- `enable` dropped or `mode` changed mid-word: the current word completes unchanged; the new values are honoured only at the next latch.
- `read` is never asserted while `empty`=1, and never for more than one cycle per word.
- Reset asserted mid-word: all state returns to reset values immediately; the partial word is discarded.

## Timing
- Latch in cycle N, so `read`=1 in N. The first `pwm` level of the word appears in N+1, as does the `symb_clk` toggle. `busy`=1 from N+1.
- Back-to-back words: `read` pulses exactly once every word length. The output bit stream is seamless.
- Return to IDLE: `pwm`=0 and `busy`=0 from the cycle after the final symbol.
- `underrun_cnt` updates one cycle after the final symbol clock.
- All outputs are registered; there is no combinational path from `sample`/`empty` to `pwm`. `read` is a registered-state/combinational decode of `empty`, `enable` and `mode`, permitted because the FIFO is FWFT.

## Test plan
- AM at defaults, FIFO holds 0x40:
  - `read` pulses once.
  - `pwm` is high 64 clocks, then low 191 clocks.
  - `busy` then falls and `underrun_cnt` = 1.
- AM, three queued words 0x00, 0xFF, 0x80:
  - `read` pulses at 255-clock spacing.
  - `pwm` is 255 low, then 255 high, then 128 high / 127 low.
  - `symb_clk` toggles 3 times.
- BPSK defaults, word 0xA5:
  - Eight 16-clock bits.
  - Bits 1 are an inverted carrier (4 high/4 low, i.e. starting high); bits 0 are 4 low/4 high.
  - No phase jump at word boundaries when 0xA5, 0x5A are streamed back-to-back.
- OOK, word 0xF0: carrier for 64 clocks, then `pwm`=0 for 64 clocks.
- Mode switched AM→BPSK and `enable` dropped mid-word:
  - The current AM word finishes intact.
  - With `enable`=0, IDLE is entered with no underrun counted.
  - When re-enabled, the next word is BPSK.
- Reset pulsed low mid-word, with `UNDERRUN_WIDTH`=2 and 5 forced underruns:
  - All outputs return to reset values asynchronously.
  - Before the reset, the counter saturates at 3.
